// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_access_unit                                              |
// | Description : MEM-stage load/store unit. Runs the access in mem_mem_op     |
// |               against data memory over a req/ack handshake, aligns and     |
// |               extends load data, and registers the MEM_WB bundle.          |
// |               The upstream pipeline is held via stall_req while the bus    |
// |               access is in flight.                                         |
// | Ports       : clk, rst (async, active-low)                                 |
// |               mem_*      : EXE_MEM register contents (pc, op, addr, data,   |
// |                            we, write_reg, write_data)                      |
// |               dmem_*     : data-memory request/response                     |
// |               stall_req  : hold EXE_MEM and earlier stages                 |
// |               misalign_exc, bus_err : one-cycle exception pulses           |
// |               wb_*       : registered write-back bundle                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_access_unit #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_pc,
    input  logic [3:0]  mem_mem_op,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_mem_data,
    input  logic        mem_we,
    input  logic [4:0]  mem_write_reg,
    input  logic [31:0] mem_write_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_req,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic [31:0] wb_pc,
    output logic        wb_we,
    output logic [4:0]  wb_write_reg,
    output logic [31:0] wb_write_data
);

    localparam logic [3:0] c_OP_LB  = 4'd1;
    localparam logic [3:0] c_OP_LBU = 4'd2;
    localparam logic [3:0] c_OP_LH  = 4'd3;
    localparam logic [3:0] c_OP_LHU = 4'd4;
    localparam logic [3:0] c_OP_LW  = 4'd5;
    localparam logic [3:0] c_OP_SB  = 4'd6;
    localparam logic [3:0] c_OP_SH  = 4'd7;
    localparam logic [3:0] c_OP_SW  = 4'd8;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [7:0]  r_cnt;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_dmem_we;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;
    logic [3:0]  r_dmem_be;
    logic        r_misalign;
    logic        r_bus_err;
    logic [31:0] r_wb_pc;
    logic        r_wb_we;
    logic [4:0]  r_wb_write_reg;
    logic [31:0] r_wb_write_data;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misalign;
    logic        w_access;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_wb_data;
    logic        w_wb_we_base;

    // Opcode decode; unknown encodings fall through as NOP.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_is_byte  = 1'b0;
        w_is_half  = 1'b0;
        w_is_word  = 1'b0;
        case (mem_mem_op)
            c_OP_LB, c_OP_LBU: begin w_is_load  = 1'b1; w_is_byte = 1'b1; end
            c_OP_LH, c_OP_LHU: begin w_is_load  = 1'b1; w_is_half = 1'b1; end
            c_OP_LW:           begin w_is_load  = 1'b1; w_is_word = 1'b1; end
            c_OP_SB:           begin w_is_store = 1'b1; w_is_byte = 1'b1; end
            c_OP_SH:           begin w_is_store = 1'b1; w_is_half = 1'b1; end
            c_OP_SW:           begin w_is_store = 1'b1; w_is_word = 1'b1; end
            default: ;
        endcase
    end

    assign w_misalign = (w_is_half && mem_mem_addr[0]) ||
                        (w_is_word && (mem_mem_addr[1:0] != 2'b00));
    assign w_access   = (w_is_load || w_is_store) && !w_misalign;

    // Store lane steering: data is replicated across all lanes so the byte
    // enables alone select where it lands. Loads always fetch the full word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = mem_mem_data;
        if (w_is_store && w_is_byte) begin
            w_be    = 4'b0001 << mem_mem_addr[1:0];
            w_wdata = {4{mem_mem_data[7:0]}};
        end else if (w_is_store && w_is_half) begin
            w_be    = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{mem_mem_data[15:0]}};
        end
    end

    // Load alignment uses the captured word; the address input is still
    // stable during DONE because upstream only advances at that edge.
    always_comb begin
        case (mem_mem_addr[1:0])
            2'd0:    w_byte = r_rdata[7:0];
            2'd1:    w_byte = r_rdata[15:8];
            2'd2:    w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase
        w_half = mem_mem_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
        case (mem_mem_op)
            c_OP_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: w_load_data = {24'd0, w_byte};
            c_OP_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            c_OP_LHU: w_load_data = {16'd0, w_half};
            default:  w_load_data = r_rdata;
        endcase
    end

    assign w_wb_data    = w_is_load ? w_load_data : mem_write_data;
    assign w_wb_we_base = mem_we && (mem_write_reg != 5'd0) && !w_is_store;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (w_access) w_next_state = c_REQ;
            c_REQ:  if (dmem_ack || (r_cnt == TIMEOUT - 8'd1)) w_next_state = c_DONE;
            c_DONE: w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= c_IDLE;
            r_cnt           <= 8'd0;
            r_err           <= 1'b0;
            r_rdata         <= 32'd0;
            r_dmem_we       <= 1'b0;
            r_dmem_addr     <= 32'd0;
            r_dmem_wdata    <= 32'd0;
            r_dmem_be       <= 4'd0;
            r_misalign      <= 1'b0;
            r_bus_err       <= 1'b0;
            r_wb_pc         <= 32'd0;
            r_wb_we         <= 1'b0;
            r_wb_write_reg  <= 5'd0;
            r_wb_write_data <= 32'd0;
        end else begin
            r_state    <= w_next_state;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_cnt <= 8'd0;
                    r_err <= 1'b0;
                    if (w_access) begin
                        r_dmem_we    <= w_is_store;
                        r_dmem_addr  <= {mem_mem_addr[31:2], 2'b00};
                        r_dmem_wdata <= w_wdata;
                        r_dmem_be    <= w_be;
                    end else begin
                        // NOP or misaligned access: write back immediately.
                        r_wb_pc         <= mem_pc;
                        r_wb_we         <= w_wb_we_base && !w_misalign;
                        r_wb_write_reg  <= mem_write_reg;
                        r_wb_write_data <= mem_write_data;
                        r_misalign      <= w_misalign;
                    end
                end
                c_REQ: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (dmem_ack) begin
                        r_rdata <= dmem_rdata;
                    end else if (r_cnt == TIMEOUT - 8'd1) begin
                        r_err <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_wb_pc         <= mem_pc;
                    r_wb_we         <= w_wb_we_base && !r_err;
                    r_wb_write_reg  <= mem_write_reg;
                    r_wb_write_data <= w_wb_data;
                    r_bus_err       <= r_err;
                end
                default: ;
            endcase
        end
    end

    assign dmem_req      = (r_state == c_REQ);
    assign dmem_we       = r_dmem_we;
    assign dmem_addr     = r_dmem_addr;
    assign dmem_wdata    = r_dmem_wdata;
    assign dmem_be       = r_dmem_be;
    // Gated by reset so the request path stays quiet while reset is held.
    assign stall_req     = rst && (((r_state == c_IDLE) && w_access) || (r_state == c_REQ));
    assign misalign_exc  = r_misalign;
    assign bus_err       = r_bus_err;
    assign wb_pc         = r_wb_pc;
    assign wb_we         = r_wb_we;
    assign wb_write_reg  = r_wb_write_reg;
    assign wb_write_data = r_wb_write_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_access_unit                                           |
// | Description : Self-checking bench for mem_access_unit. Each instruction's  |
// |               expected cycle-by-cycle behaviour and write-back result is   |
// |               derived from the load/store rules with plain arithmetic.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_pc;
    logic [3:0]  mem_mem_op;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_mem_data;
    logic        mem_we;
    logic [4:0]  mem_write_reg;
    logic [31:0] mem_write_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall_req;
    logic        misalign_exc;
    logic        bus_err;
    logic [31:0] wb_pc;
    logic        wb_we;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;

    int n_vec  = 0;
    int n_fail = 0;

    mem_access_unit #(.TIMEOUT(8'd4)) dut (
        .clk(clk), .rst(rst),
        .mem_pc(mem_pc), .mem_mem_op(mem_mem_op), .mem_mem_addr(mem_mem_addr),
        .mem_mem_data(mem_mem_data), .mem_we(mem_we), .mem_write_reg(mem_write_reg),
        .mem_write_data(mem_write_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall_req(stall_req),
        .misalign_exc(misalign_exc), .bus_err(bus_err),
        .wb_pc(wb_pc), .wb_we(wb_we), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data)
    );

    always #5 clk = ~clk;

    // One instruction from arrival to write-back. ack_cyc is the REQ cycle
    // (1-based) in which the memory acknowledges; beyond TMO means never.
    // Called at 1 time unit after a rising edge with the unit idle.
    task automatic run_txn(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] pc,
                           input logic we, input logic [4:0] wreg,
                           input logic [31:0] wdata, input int ack_cyc,
                           input logic [31:0] rdata);
        bit ld, st, sx, mis, acc, err;
        int size, n;
        logic [31:0] e_addr, e_wdata, e_ld, e_wbdata, mask, sh;
        logic [3:0]  e_be;
        logic        e_wbwe;
        ld   = (op >= 4'd1 && op <= 4'd5);
        st   = (op >= 4'd6 && op <= 4'd8);
        sx   = (op == 4'd1 || op == 4'd3);
        size = (op == 4'd1 || op == 4'd2 || op == 4'd6) ? 1 :
               (op == 4'd3 || op == 4'd4 || op == 4'd7) ? 2 : 4;
        mis  = (ld || st) && ((addr % size) != 0);
        acc  = (ld || st) && !mis;
        err  = acc && (ack_cyc > TMO);
        n    = err ? TMO : ack_cyc;
        e_addr = addr - (addr % 4);
        e_be   = st ? 4'(((1 << size) - 1) << (addr % 4)) : 4'hF;
        e_wdata = (size == 1) ? (data & 32'hFF)   * 32'h0101_0101 :
                  (size == 2) ? (data & 32'hFFFF) * 32'h0001_0001 : data;
        sh   = 8 * (addr % 4);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        e_ld = (rdata >> sh) & mask;
        if (sx && ((e_ld & ~(mask >> 1)) != 0)) e_ld = e_ld | ~mask;
        e_wbdata = ld ? e_ld : wdata;
        e_wbwe   = we && (wreg != 0) && !st && !mis && !err;

        mem_mem_op = op; mem_mem_addr = addr; mem_mem_data = data; mem_pc = pc;
        mem_we = we; mem_write_reg = wreg; mem_write_data = wdata;
        dmem_ack = 1'($urandom % 2);   // stray ack while idle must be ignored
        dmem_rdata = $urandom;
        @(negedge clk);
        n_vec++;
        if ({dmem_req, stall_req} !== {1'b0, acc})
            $display("FAIL arrive op=%0d: got req/stall=%b required=%b", op,
                     {dmem_req, stall_req}, {1'b0, acc});
        if ({dmem_req, stall_req} !== {1'b0, acc}) n_fail++;
        if (acc) begin
            for (int i = 1; i <= n; i++) begin
                @(posedge clk); #1;
                dmem_ack   = (i == ack_cyc);
                dmem_rdata = (i == ack_cyc) ? rdata : $urandom;
                @(negedge clk);
                n_vec++;
                if ({dmem_req, stall_req, dmem_we, dmem_be, dmem_addr} !== {2'b11, st, e_be, e_addr}) begin
                    n_fail++;
                    $display("FAIL req_cycle%0d op=%0d: got req,stall,we,be,addr=%b%b%b %b %h required %b%b%b %b %h",
                             i, op, dmem_req, stall_req, dmem_we, dmem_be, dmem_addr,
                             1'b1, 1'b1, st, e_be, e_addr);
                end
                if (st) begin
                    n_vec++;
                    if (dmem_wdata !== e_wdata) begin
                        n_fail++;
                        $display("FAIL store_wdata op=%0d: got %h required %h", op, dmem_wdata, e_wdata);
                    end
                end
            end
            @(posedge clk); #1;
            dmem_ack = 1'($urandom % 2);
            dmem_rdata = $urandom;
            @(negedge clk);
            n_vec++;
            if ({dmem_req, stall_req} !== 2'b00) begin
                n_fail++;
                $display("FAIL done op=%0d: got req/stall=%b required 00", op, {dmem_req, stall_req});
            end
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        n_vec++;
        if ({wb_pc, wb_we, wb_write_reg, misalign_exc, bus_err} !== {pc, e_wbwe, wreg, mis, err}) begin
            n_fail++;
            $display("FAIL wb op=%0d: got pc=%h we=%b rd=%0d mis=%b berr=%b required pc=%h we=%b rd=%0d mis=%b berr=%b",
                     op, wb_pc, wb_we, wb_write_reg, misalign_exc, bus_err, pc, e_wbwe, wreg, mis, err);
        end
        if (!mis && !err) begin
            n_vec++;
            if (wb_write_data !== e_wbdata) begin
                n_fail++;
                $display("FAIL wb_data op=%0d addr=%h: got %h required %h", op, addr, wb_write_data, e_wbdata);
            end
        end
    endtask

    task automatic test_reset_initial();
        rst = 1'b0;
        mem_pc = 32'h0; mem_mem_op = 4'd5; mem_mem_addr = 32'h0; mem_mem_data = 32'h0;
        mem_we = 1'b1; mem_write_reg = 5'd1; mem_write_data = 32'h0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall_req, misalign_exc, bus_err,
             wb_pc, wb_we, wb_write_reg, wb_write_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got req=%b stall=%b wb_pc=%h wb_we=%b required all zero",
                     dmem_req, stall_req, wb_pc, wb_we);
        end
        mem_mem_op = 4'd0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nop();
        run_txn(4'd0, 32'h0000_0103, 32'h0, 32'h0000_0040, 1'b1, 5'd5, 32'h1234, 1, 32'h0);
        run_txn(4'd12, 32'h0000_0000, 32'h0, 32'h0000_0044, 1'b1, 5'd0, 32'h5555, 1, 32'h0);
        run_txn(4'd15, 32'h0000_0002, 32'h0, 32'h0000_0048, 1'b1, 5'd31, 32'hCAFE, 1, 32'h0);
    endtask

    task automatic test_load_extend();
        run_txn(4'd1, 32'h0000_0103, 32'h0, 32'h0000_0100, 1'b1, 5'd7, 32'hDEAD, 1, 32'h80FF_0000);
        run_txn(4'd2, 32'h0000_0103, 32'h0, 32'h0000_0104, 1'b1, 5'd7, 32'hDEAD, 1, 32'h80FF_0000);
        run_txn(4'd3, 32'h0000_0202, 32'h0, 32'h0000_0108, 1'b1, 5'd8, 32'h0, 2, 32'h8001_7FFF);
        run_txn(4'd4, 32'h0000_0202, 32'h0, 32'h0000_010C, 1'b1, 5'd8, 32'h0, 3, 32'h8001_7FFF);
        run_txn(4'd5, 32'h0000_0300, 32'h0, 32'h0000_0110, 1'b1, 5'd0, 32'h0, 1, 32'h1234_5678);
    endtask

    task automatic test_store_lanes();
        run_txn(4'd7, 32'h0000_0022, 32'h0000_ABCD, 32'h0000_0200, 1'b1, 5'd9, 32'h1, 1, 32'h0);
        run_txn(4'd6, 32'h0000_0011, 32'h1234_56A5, 32'h0000_0204, 1'b1, 5'd9, 32'h1, 2, 32'h0);
        run_txn(4'd8, 32'h0000_0040, 32'hF00D_BEEF, 32'h0000_0208, 1'b1, 5'd9, 32'h1, 1, 32'h0);
    endtask

    task automatic test_misalign();
        run_txn(4'd5, 32'h0000_0006, 32'h0, 32'h0000_0300, 1'b1, 5'd3, 32'h77, 1, 32'h0);
        run_txn(4'd7, 32'h0000_0021, 32'h0, 32'h0000_0304, 1'b1, 5'd3, 32'h77, 1, 32'h0);
        run_txn(4'd3, 32'h0000_0023, 32'h0, 32'h0000_0308, 1'b1, 5'd3, 32'h77, 1, 32'h0);
    endtask

    task automatic test_timeout();
        run_txn(4'd5, 32'h0000_0010, 32'h0, 32'h0000_0400, 1'b1, 5'd4, 32'h0, 99, 32'h0);
        run_txn(4'd5, 32'h0000_0014, 32'h0, 32'h0000_0404, 1'b1, 5'd4, 32'h0, TMO, 32'hA5A5_5A5A);
        run_txn(4'd8, 32'h0000_0018, 32'h1, 32'h0000_0408, 1'b1, 5'd4, 32'h0, TMO + 1, 32'h0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_txn(4'(1 + (i % 8)), 32'h0000_0800 + 32'(4 * i), $urandom, 32'h0000_0500 + 32'(4 * i),
                    1'b1, 5'(i + 1), $urandom, 1, $urandom);
    endtask

    task automatic test_reset_mid_req();
        mem_mem_op = 4'd1; mem_mem_addr = 32'h0000_0100; mem_pc = 32'h0000_0600;
        mem_we = 1'b1; mem_write_reg = 5'd12; mem_write_data = 32'h0;
        dmem_ack = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if (dmem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_setup: got dmem_req=%b required 1", dmem_req);
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall_req, misalign_exc, bus_err,
             wb_pc, wb_we, wb_write_reg, wb_write_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got req=%b stall=%b wb_pc=%h wb_we=%b required all zero",
                     dmem_req, stall_req, wb_pc, wb_we);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        mem_mem_op = 4'd0; mem_write_reg = 5'd3; mem_pc = 32'h0000_0700; mem_write_data = 32'h99;
        #1;
        n_vec++;
        if ({dmem_req, stall_req, wb_we, misalign_exc, bus_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_release: got req,stall,wb_we,mis,berr=%b required 00000",
                     {dmem_req, stall_req, wb_we, misalign_exc, bus_err});
        end
        @(posedge clk); #1;
        n_vec++;
        if ({wb_we, wb_write_reg, wb_pc} !== {1'b1, 5'd3, 32'h0000_0700}) begin
            n_fail++;
            $display("FAIL reset_resume: got we=%b rd=%0d pc=%h required we=1 rd=3 pc=00000700",
                     wb_we, wb_write_reg, wb_pc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++)
            run_txn(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, 1'($urandom % 2),
                    5'($urandom), $urandom, $urandom_range(1, TMO + 2), $urandom);
    endtask

    initial begin
        test_reset_initial();
        test_nop();
        test_load_extend();
        test_store_lanes();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_mid_req();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required completion before time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
